// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback port, issue reservation and flush.
// The master drives addresses/requests; the slave (register file) returns data and status.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rbusy1;
    logic            rbusy2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic            flush;

    modport master (
        output ra1, ra2, we, wa, wd, iss_valid, iss_rd, flush,
        input  rd1, rd2, rbusy1, rbusy2, iss_ready
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, iss_valid, iss_rd, flush,
        output rd1, rd2, rbusy1, rbusy2, iss_ready
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0] mem_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            rbusy1_s;
    logic            rbusy2_s;
    logic            iss_ready_s;
    logic            wr_en_s;
    logic            iss_accept_s;
    logic            fwd1_s;
    logic            fwd2_s;

    // Register 0 may be wired to zero: it then ignores writes and is never busy.
    function automatic logic is_zero(input logic [AW-1:0] addr);
        is_zero = (ZERO_REG != 0) && (addr == {AW{1'b0}});
    endfunction

    assign wr_en_s      = bus.we && !is_zero(bus.wa);
    assign iss_accept_s = bus.iss_valid && iss_ready_s;
    assign fwd1_s       = (BYPASS != 0) && bus.we && (bus.wa == bus.ra1);
    assign fwd2_s       = (BYPASS != 0) && bus.we && (bus.wa == bus.ra2);

    // Read port 1: a forwarded write delivers its value now, so it is not pending.
    always_comb begin
        rd1_s    = {XLEN{1'b0}};
        rbusy1_s = 1'b0;
        if (is_zero(bus.ra1)) begin
            rd1_s    = {XLEN{1'b0}};
            rbusy1_s = 1'b0;
        end else if (fwd1_s) begin
            rd1_s    = bus.wd;
            rbusy1_s = 1'b0;
        end else begin
            rd1_s    = mem_r[bus.ra1];
            rbusy1_s = busy_r[bus.ra1];
        end
    end

    // Read port 2: identical rules to port 1.
    always_comb begin
        rd2_s    = {XLEN{1'b0}};
        rbusy2_s = 1'b0;
        if (is_zero(bus.ra2)) begin
            rd2_s    = {XLEN{1'b0}};
            rbusy2_s = 1'b0;
        end else if (fwd2_s) begin
            rd2_s    = bus.wd;
            rbusy2_s = 1'b0;
        end else begin
            rd2_s    = mem_r[bus.ra2];
            rbusy2_s = busy_r[bus.ra2];
        end
    end

    // WAW stall: a busy destination may issue only when its writeback lands this cycle.
    always_comb begin
        iss_ready_s = 1'b0;
        if (!rst_n || bus.flush) begin
            iss_ready_s = 1'b0;
        end else if (is_zero(bus.iss_rd)) begin
            iss_ready_s = 1'b1;
        end else if (!busy_r[bus.iss_rd] || (bus.we && (bus.wa == bus.iss_rd))) begin
            iss_ready_s = 1'b1;
        end else begin
            iss_ready_s = 1'b0;
        end
    end

    // Next busy bits, priority flush > issue-set > write-clear.
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 0; i < NREG; i++) begin
            if (bus.flush) begin
                busy_next_s[i] = 1'b0;
            end else if (iss_accept_s && (bus.iss_rd == AW'(i)) && !is_zero(bus.iss_rd)) begin
                busy_next_s[i] = 1'b1;
            end else if (wr_en_s && (bus.wa == AW'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Storage and scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[bus.wa] <= bus.wd;
            end
            busy_r <= busy_next_s;
        end
    end

    assign bus.rd1       = rd1_s;
    assign bus.rd2       = rd2_s;
    assign bus.rbusy1    = rbusy1_s;
    assign bus.rbusy2    = rbusy2_s;
    assign bus.iss_ready = iss_ready_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass + zero reg, and neither) share one
// stimulus stream and are checked against a behavioural model every cycle.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, iss_rd;
    logic [31:0] wd;
    logic        we, iss_valid, flush;
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad   = 0;

    logic [31:0] m_mem  [2][32];
    logic [31:0] m_busy [2];

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .AW(5)) bus_a ();
    regfile_sb_if #(.XLEN(32), .AW(5)) bus_b ();

    assign bus_a.ra1 = ra1;             assign bus_b.ra1 = ra1;
    assign bus_a.ra2 = ra2;             assign bus_b.ra2 = ra2;
    assign bus_a.we = we;               assign bus_b.we = we;
    assign bus_a.wa = wa;               assign bus_b.wa = wa;
    assign bus_a.wd = wd;               assign bus_b.wd = wd;
    assign bus_a.iss_valid = iss_valid; assign bus_b.iss_valid = iss_valid;
    assign bus_a.iss_rd = iss_rd;       assign bus_b.iss_rd = iss_rd;
    assign bus_a.flush = flush;         assign bus_b.flush = flush;

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Instance 0 has zero register and bypass; instance 1 has neither.
    function automatic bit zaddr(input int k, input logic [4:0] a);
        return (k == 0) && (a == 5'd0);
    endfunction

    function automatic bit bp(input int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] ra);
        if (zaddr(k, ra)) return 32'd0;
        if (bp(k) && we && wa == ra) return wd;
        return m_mem[k][ra];
    endfunction

    function automatic logic exp_busy(input int k, input logic [4:0] ra);
        if (zaddr(k, ra)) return 1'b0;
        if (bp(k) && we && wa == ra) return 1'b0;
        return m_busy[k][ra];
    endfunction

    function automatic logic exp_ready(input int k);
        if (!rst_n || flush) return 1'b0;
        if (zaddr(k, iss_rd)) return 1'b1;
        if (!m_busy[k][iss_rd]) return 1'b1;
        if (we && wa == iss_rd) return 1'b1;
        return 1'b0;
    endfunction

    // Apply effects in increasing priority so later rules override earlier ones.
    function automatic logic [31:0] next_busy(input int k);
        logic [31:0] nb;
        nb = m_busy[k];
        if (we && !zaddr(k, wa)) nb[wa] = 1'b0;
        if (iss_valid && exp_ready(k) && !zaddr(k, iss_rd)) nb[iss_rd] = 1'b1;
        if (flush) nb = 32'd0;
        return nb;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int j = 0; j < 32; j++) m_mem[k][j] <= 32'd0;
                m_busy[k] <= 32'd0;
            end else begin
                if (we && !zaddr(k, wa)) m_mem[k][wa] <= wd;
                m_busy[k] <= next_busy(k);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.rd1", bus_a.rd1, exp_rd(0, ra1));
            check("a.rd2", bus_a.rd2, exp_rd(0, ra2));
            check("a.rbusy1", {31'd0, bus_a.rbusy1}, {31'd0, exp_busy(0, ra1)});
            check("a.rbusy2", {31'd0, bus_a.rbusy2}, {31'd0, exp_busy(0, ra2)});
            check("a.iss_ready", {31'd0, bus_a.iss_ready}, {31'd0, exp_ready(0)});
            check("b.rd1", bus_b.rd1, exp_rd(1, ra1));
            check("b.rd2", bus_b.rd2, exp_rd(1, ra2));
            check("b.rbusy1", {31'd0, bus_b.rbusy1}, {31'd0, exp_busy(1, ra1)});
            check("b.rbusy2", {31'd0, bus_b.rbusy2}, {31'd0, exp_busy(1, ra2)});
            check("b.iss_ready", {31'd0, bus_b.iss_ready}, {31'd0, exp_ready(1)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_rd = 5'd3; flush = 1'b0; ra1 = 5'd3; ra2 = 5'd0;
        cyc();
        chk_en = 1'b1;
        #1 check("rst.iss_ready_a", {31'd0, bus_a.iss_ready}, 32'd0);
        check("rst.iss_ready_b", {31'd0, bus_b.iss_ready}, 32'd0);
        cyc();

        rst_n = 1'b1; we = 1'b0; iss_valid = 1'b0;
        #2 check("rst.a.rd1_r3", bus_a.rd1, 32'd0);
        check("rst.b.rd1_r3", bus_b.rd1, 32'd0);
        check("rst.a.rbusy1", {31'd0, bus_a.rbusy1}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            cyc();
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #2 check("rst.b.busy_scan", {31'd0, bus_b.rbusy1}, 32'd0);
        end
        cyc();

        we = 1'b1; wa = 5'd5; wd = 32'h12345678;
        cyc();
        wa = 5'd0; wd = 32'hFFFFFFFF;
        cyc();
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
        #2 check("wr.a.rd1_r5", bus_a.rd1, 32'h12345678);
        check("wr.a.rd2_r0", bus_a.rd2, 32'd0);
        check("wr.b.rd2_r0", bus_b.rd2, 32'hFFFFFFFF);
        cyc();

        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd7;
        #2 check("byp.a.rd1", bus_a.rd1, 32'hA5A5A5A5);
        check("byp.b.rd1_old", bus_b.rd1, 32'd0);
        cyc();
        we = 1'b0;
        #2 check("byp.b.rd1_next", bus_b.rd1, 32'hA5A5A5A5);
        check("byp.b.rd2_same", bus_b.rd2, 32'hA5A5A5A5);
        cyc();

        iss_valid = 1'b1; iss_rd = 5'd9; ra1 = 5'd9;
        #2 check("sb.ready_free", {31'd0, bus_a.iss_ready}, 32'd1);
        cyc();
        iss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 check("sb.a.rbusy1_stall", {31'd0, bus_a.rbusy1}, 32'd1);
            check("sb.a.ready_stall", {31'd0, bus_a.iss_ready}, 32'd0);
            cyc();
        end
        we = 1'b1; wa = 5'd9; wd = 32'h00000055;
        #2 check("sb.a.rbusy1_wb", {31'd0, bus_a.rbusy1}, 32'd0);
        check("sb.a.ready_wb", {31'd0, bus_a.iss_ready}, 32'd1);
        check("sb.b.rbusy1_wb", {31'd0, bus_b.rbusy1}, 32'd1);
        cyc();
        we = 1'b0;
        #2 check("sb.a.rbusy1_after", {31'd0, bus_a.rbusy1}, 32'd0);
        check("sb.b.rd1_after", bus_b.rd1, 32'h00000055);
        cyc();

        iss_valid = 1'b1; iss_rd = 5'd4;
        cyc();
        we = 1'b1; wa = 5'd4; wd = 32'h00000044; ra1 = 5'd4;
        #2 check("iw.ready", {31'd0, bus_a.iss_ready}, 32'd1);
        cyc();
        iss_valid = 1'b0; we = 1'b0;
        #2 check("iw.a.rd1", bus_a.rd1, 32'h00000044);
        check("iw.a.rbusy1", {31'd0, bus_a.rbusy1}, 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd0; ra2 = 5'd0;
        cyc();
        iss_valid = 1'b0;
        #2 check("z.a.rbusy2_r0", {31'd0, bus_a.rbusy2}, 32'd0);
        check("z.b.rbusy2_r0", {31'd0, bus_b.rbusy2}, 32'd1);
        cyc();

        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1;
            iss_rd = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd31;
            cyc();
        end
        ra1 = 5'd31;
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6; we = 1'b1; wa = 5'd2; wd = 32'hCAFE0002;
        #2 check("fl.a.ready", {31'd0, bus_a.iss_ready}, 32'd0);
        check("fl.a.rbusy1_r31", {31'd0, bus_a.rbusy1}, 32'd1);
        cyc();
        flush = 1'b0; iss_valid = 1'b0; we = 1'b0; ra2 = 5'd2;
        #2 check("fl.a.rd2_r2", bus_a.rd2, 32'hCAFE0002);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #2 check("fl.a.busy_scan", {31'd0, bus_a.rbusy1}, 32'd0);
            check("fl.b.busy_scan", {31'd0, bus_b.rbusy1}, 32'd0);
            cyc();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
